// File: rtl/reg_file_cc_if.sv
// rtl/reg_file_cc_if.sv - LC-3 register file datapath connection bundle
interface reg_file_cc_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 3
);
  logic [DATA_WIDTH-1:0] BUS;
  logic [ADDR_WIDTH-1:0] DRMUX_output;
  logic [ADDR_WIDTH-1:0] SR1MUX_output;
  logic [ADDR_WIDTH-1:0] SR2;
  logic                  LD_REG;
  logic                  LD_CC;
  logic                  LD_BEN;
  logic [2:0]            IR_11_9;
  logic [DATA_WIDTH-1:0] SR1_output;
  logic [DATA_WIDTH-1:0] SR2_output;
  logic                  N;
  logic                  Z;
  logic                  P;
  logic                  BEN;

  modport master (
    output BUS, DRMUX_output, SR1MUX_output, SR2, LD_REG, LD_CC, LD_BEN, IR_11_9,
    input  SR1_output, SR2_output, N, Z, P, BEN
  );

  modport slave (
    input  BUS, DRMUX_output, SR1MUX_output, SR2, LD_REG, LD_CC, LD_BEN, IR_11_9,
    output SR1_output, SR2_output, N, Z, P, BEN
  );
endinterface

// File: rtl/reg_file_cc.sv
// rtl/reg_file_cc.sv - LC-3 register file with NZP condition codes and branch enable
module reg_file_cc #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 3
) (
  input  logic         Clk,
  input  logic         Reset,
  reg_file_cc_if.slave rf
);
  localparam int NUM_REGS = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic [2:0]            nzp_q;
  logic                  ben_q;
  logic [2:0]            nzp_next;
  logic                  ben_next;

  // Flag values derived from the word currently on BUS
  always_comb begin
    nzp_next    = 3'b000;
    nzp_next[2] = rf.BUS[DATA_WIDTH-1];
    nzp_next[1] = (rf.BUS == '0);
    nzp_next[0] = !rf.BUS[DATA_WIDTH-1] && (rf.BUS != '0);
  end

  // Branch decision against the flags held before this edge
  always_comb begin
    ben_next = |(rf.IR_11_9 & nzp_q);
  end

  // Register write-back from BUS; reads are unbypassed
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (rf.LD_REG) begin
      regs[rf.DRMUX_output] <= rf.BUS;
    end
  end

  // Condition codes, one-hot from reset onward
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      nzp_q <= 3'b010;
    end else if (rf.LD_CC) begin
      nzp_q <= nzp_next;
    end
  end

  // Branch enable register
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      ben_q <= 1'b0;
    end else if (rf.LD_BEN) begin
      ben_q <= ben_next;
    end
  end

  assign rf.SR1_output = regs[rf.SR1MUX_output];
  assign rf.SR2_output = regs[rf.SR2];
  assign rf.N          = nzp_q[2];
  assign rf.Z          = nzp_q[1];
  assign rf.P          = nzp_q[0];
  assign rf.BEN        = ben_q;
endmodule
